rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum grant length in cycles, legal range 1..255; used only when ARB_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  8  request vector; bit k = requester k (i0..i7 ordering, bit 0 = i0).
REQ-005 Port: done  input  1  granted requester releases the resource.
REQ-006 Port: gnt  output  8  one-hot grant, registered.
REQ-007 Port: gidx  output  3  binary index of the granted requester (8-to-3 encoding of gnt), registered.
REQ-008 Port: valid  output  1  high while a grant is held.
REQ-009 Port: tmo  output  1  one-cycle pulse on forced release.
REQ-010 The design SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 Internal 3-bit pointer ptr SHALL name the highest-priority requester; search order ptr, ptr+1, ... ptr+7, modulo 8.
REQ-013 IDLE: if req != 0 at an edge, the first set bit in search order SHALL be granted; gnt, gidx, and valid=1 SHALL be visible after that edge (1-cycle latency); state -> GRANT.
REQ-014 IDLE with req == 0: outputs stay zero; done SHALL be ignored.
REQ-015 GRANT: gnt, gidx, and valid SHALL hold constant; changes on other req bits SHALL be ignored.
REQ-016 GRANT release: at an edge where done=1 OR req[gidx]=0, gnt=0, gidx=0, and valid=0 SHALL take effect after that edge; ptr SHALL become (gidx+1) mod 8; state -> IDLE.
REQ-017 At least one IDLE cycle SHALL separate consecutive grants, with valid low for one cycle.
REQ-018 Pointer wrap: gidx=7 released -> ptr=0.
REQ-019 gidx SHALL always equal the encoded index of the single set gnt bit; gnt SHALL never have more than one bit set.

Reset
REQ-020 rst=1 SHALL immediately force gnt=0, gidx=0, valid=0, tmo=0, ptr=0, state IDLE, and hold counter 0, regardless of the clock.
REQ-021 Reset during GRANT SHALL abort the grant without updating ptr from gidx.
REQ-022 The first edge after rst falls SHALL be evaluated as IDLE with ptr=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-024 With ARB_TIMEOUT_EN defined: if no release occurs by the HOLD_MAX-th GRANT cycle, the block SHALL perform a forced release identical to REQ-016 and pulse tmo=1 for one cycle.
REQ-025 With ARB_TIMEOUT_EN defined: done (or a dropped req) on the same edge as the timeout SHALL count as a normal release, with tmo=0.
REQ-026 ARB_TIMEOUT_EN undefined: no counter SHALL exist, tmo SHALL be tied 0, and grants SHALL be held indefinitely until release.

Verification
REQ-027 Single requester: after reset, req=8'b00000100 -> next cycle gnt=8'b00000100, gidx=3'd2, valid=1; done=1 for one cycle -> gnt=0, valid=0, ptr=3.
REQ-028 Fairness: req=8'hFF held, done pulsed once per grant -> grant order gidx 0,1,2,...,7,0, with one valid-low cycle between grants.
REQ-029 Wrap and skip: ptr=6, req=8'b00000011 -> gidx=0; after release, gidx=1.
REQ-030 Ignore others: during a grant to 3, toggling req[5] -> gnt is unchanged; dropping req[3] -> release on that edge.
REQ-031 Reset mid-grant: asserting rst between edges during a gidx=5 grant -> gnt=0 and valid=0 immediately; after reset, req=8'hFF -> gidx=0.
REQ-032 With ARB_TIMEOUT_EN defined and HOLD_MAX=4: a grant with no done is released after 4 cycles with a tmo pulse; with done on cycle 4, the release occurs with tmo=0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot grant and optional hold timeout
// Ports: clk, rst (async active-high); req[7:0] requests (bit k = requester k); done releases the grant;
//        gnt[7:0] one-hot grant, gidx[2:0] its encoded index, valid high while a grant is held,
//        tmo one-cycle pulse on forced release.
// Optional feature macro: ARB_TIMEOUT_EN enables the HOLD_MAX-cycle hold limit; otherwise tmo is tied 0.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gidx,
    output logic       valid,
    output logic       tmo
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [2:0] ptr, ptr_n, sel, gidx_n;
    logic [7:0] gnt_n;
    logic valid_n, rel, fin;
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt, cnt_n;
    logic tmo_n;
`endif

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_arbiter8: HOLD_MAX must be 1..255");
    end

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        sel = ptr;
        for (int i = 7; i >= 0; i--)
            if (req[ptr + 3'(i)]) sel = ptr + 3'(i);
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt;
        gidx_n  = gidx;
        valid_n = valid;
        rel     = done || !req[gidx];
`ifdef ARB_TIMEOUT_EN
        cnt_n = cnt;
        tmo_n = 1'b0;
        fin   = rel || cnt == 8'(HOLD_MAX - 1);
`else
        fin   = rel;
`endif
        if (state == IDLE) begin
            if (|req) begin
                state_n = GRANT;
                gnt_n   = 8'd1 << sel;
                gidx_n  = sel;
                valid_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
        end else if (fin) begin
            state_n = IDLE;
            gnt_n   = '0;
            gidx_n  = '0;
            valid_n = 1'b0;
            ptr_n   = gidx + 3'd1;
`ifdef ARB_TIMEOUT_EN
            tmo_n   = !rel;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else cnt_n = cnt + 8'd1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            gidx  <= '0;
            valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
            tmo   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
            gidx  <= gidx_n;
            valid <= valid_n;
`ifdef ARB_TIMEOUT_EN
            cnt   <= cnt_n;
            tmo   <= tmo_n;
`endif
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: randomized and directed checks of rr_arbiter8 against a behavioural round-robin model
module tb_rr_arbiter8;
    localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, done = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] gnt;
    logic [2:0] gidx;
    logic valid, tmo;
    int errors = 0, checks = 0;

    rr_arbiter8 #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gidx(gidx), .valid(valid), .tmo(tmo)
    );

    always #5 clk = ~clk;

    // Model: who holds the resource, who is first in line, how long it has been held.
    int m_ptr = 0, m_idx = 0, m_hold = 0;
    bit m_busy = 0, m_tmo = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_idx = 0; m_hold = 0; m_busy = 0; m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (!m_busy) begin
                for (int i = 0; i < 8; i++)
                    if (!m_busy && req[(m_ptr + i) % 8]) begin
                        m_idx = (m_ptr + i) % 8; m_busy = 1; m_hold = 0;
                    end
            end else begin
                m_hold++;
                if (done || !req[m_idx] || (TE && m_hold >= HM)) begin
                    m_tmo  = !(done || !req[m_idx]);
                    m_busy = 0;
                    m_ptr  = (m_idx + 1) % 8;
                    m_idx  = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_gnt", 32'(gnt), m_busy ? (32'd1 << m_idx) : 32'd0);
        chk("model_gidx", 32'(gidx), m_busy ? 32'(m_idx) : 32'd0);
        chk("model_valid", 32'(valid), 32'(m_busy));
        chk("model_tmo", 32'(tmo), 32'(m_tmo));
    end

    task automatic step(input logic [7:0] r, input logic d);
        req = r; done = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; done = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0); chk("rst_gidx", 32'(gidx), 0);
        chk("rst_valid", 32'(valid), 0); chk("rst_tmo", 32'(tmo), 0);
        #1 rst = 1'b0;
        step(8'h04, 0);
        chk("single_gnt", 32'(gnt), 32'h04); chk("single_gidx", 32'(gidx), 2); chk("single_valid", 32'(valid), 1);
        step(8'h04, 1);
        chk("single_rel_gnt", 32'(gnt), 0); chk("single_rel_valid", 32'(valid), 0);
        step(8'hFF, 0);
        chk("ptr_after_2", 32'(gidx), 3);
        step(8'hFF, 1);
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 0);
            chk("fair_gidx", 32'(gidx), 32'(k % 8)); chk("fair_valid", 32'(valid), 1);
            step(8'hFF, 1);
            chk("fair_gap", 32'(valid), 0);
        end
        do_reset();
        step(8'h20, 0); chk("wrap_pre", 32'(gidx), 5);
        step(8'h20, 1);
        step(8'h03, 0); chk("wrap_skip0", 32'(gidx), 0);
        step(8'h03, 1);
        step(8'h03, 0); chk("wrap_next1", 32'(gidx), 1);
        step(8'h03, 1);
        step(8'h08, 0); chk("ign_gidx", 32'(gidx), 3);
        step(8'h28, 0); chk("ign_set5", 32'(gnt), 32'h08);
        step(8'h08, 0); chk("ign_clr5", 32'(gnt), 32'h08);
        step(8'h20, 0); chk("drop_rel", 32'(valid), 0);
        step(8'h20, 0); chk("mid_gidx", 32'(gidx), 5);
        #2 rst = 1'b1;
        #1 chk("async_gnt", 32'(gnt), 0); chk("async_valid", 32'(valid), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        step(8'hFF, 0); chk("post_rst_gidx", 32'(gidx), 0);
        step(8'hFF, 1);
`ifdef ARB_TIMEOUT_EN
        do_reset();
        step(8'h01, 0); chk("to_grant", 32'(valid), 1);
        repeat (3) begin step(8'h01, 0); chk("to_hold", 32'(valid), 1); chk("to_hold_tmo", 32'(tmo), 0); end
        step(8'h01, 0); chk("to_rel", 32'(valid), 0); chk("to_pulse", 32'(tmo), 1);
        step(8'h00, 0); chk("to_pulse_end", 32'(tmo), 0);
        step(8'h02, 0); chk("to_done_gidx", 32'(gidx), 1);
        repeat (3) step(8'h02, 0);
        step(8'h02, 1); chk("to_done_rel", 32'(valid), 0); chk("to_done_tmo", 32'(tmo), 0);
`endif
        do_reset();
        repeat (3000) begin
            logic [7:0] r;
            r = req;
            if ($urandom_range(0, 4) == 0) r = 8'($urandom);
            if ($urandom_range(0, 9) == 0) r = '0;
            if ($urandom_range(0, 5) == 0) r = r ^ (8'd1 << $urandom_range(0, 7));
            step(r, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 chk("rnd_async_gnt", 32'(gnt), 0);
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
